// File: rtl/acc_bank.sv
// acc_bank: CHANNELS independent WIDTH-bit accumulators, one LOAD/ADD/SUB/CLEAR
// per accepted request, results returned through a single registered output
// stage with valid/ready handshaking.
// Optional build macro: ACC_BANK_SAT_EN selects saturating ADD/SUB instead of
// modulo-2^WIDTH wrap-around. Overflow flags are identical in both builds.

// One accumulator channel: computes its candidate next value and overflow
// every cycle and commits it when selected.
module acc_bank_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             ovf_o,
  output logic             sticky_o
);
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH:0]   sum, diff;

  // Next value and overflow for the requested op on this channel.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, data_i};
    diff  = {1'b0, acc_q} - {1'b0, data_i};
    nxt_o = acc_q;
    ovf_o = 1'b0;
    case (op_i)
      OP_LOAD:  nxt_o = data_i;
      OP_ADD: begin
        ovf_o = sum[WIDTH];
`ifdef ACC_BANK_SAT_EN
        nxt_o = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        nxt_o = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        // Top bit of the extended difference is the borrow (data > acc).
        ovf_o = diff[WIDTH];
`ifdef ACC_BANK_SAT_EN
        nxt_o = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        nxt_o = diff[WIDTH-1:0];
`endif
      end
      OP_CLEAR: nxt_o = '0;
    endcase
  end

  // Sticky flag: LOAD/CLEAR wipe history, any overflowing op sets it.
  always_comb begin
    sticky_d = sticky_q;
    if (op_i == OP_LOAD || op_i == OP_CLEAR) sticky_d = 1'b0;
    else if (ovf_o)                          sticky_d = 1'b1;
    acc_d = nxt_o;
  end

  // Commit value and sticky only when this channel is the accept target.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else if (sel_i) begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

  assign sticky_o = sticky_q;
endmodule

module acc_bank #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int CH_W     = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_ovf,
  output logic [CHANNELS-1:0] ovf_sticky
);
  logic                            accept, ch_ok;
  logic [CHANNELS-1:0]             lane_sel, lane_ovf;
  logic [CHANNELS-1:0][WIDTH-1:0]  lane_nxt;
  logic [WIDTH-1:0]                res_data;
  logic                            res_ovf;

  logic                            out_valid_q, out_valid_d;
  logic [CH_W-1:0]                 out_ch_q, out_ch_d;
  logic [WIDTH-1:0]                out_data_q, out_data_d;
  logic                            out_ovf_q, out_ovf_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Out-of-range channel codes only exist when CHANNELS is not a power of two.
  if (CHANNELS == (1 << CH_W)) begin : g_pow2
    assign ch_ok = 1'b1;
  end else begin : g_npow2
    assign ch_ok = ({1'b0, in_ch} < (CH_W+1)'(CHANNELS));
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign lane_sel[i] = accept && ch_ok && (in_ch == CH_W'(i));
    acc_bank_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .sel_i   (lane_sel[i]),
      .op_i    (in_op),
      .data_i  (in_data),
      .nxt_o   (lane_nxt[i]),
      .ovf_o   (lane_ovf[i]),
      .sticky_o(ovf_sticky[i])
    );
  end

  // Pick the addressed lane's result for the output register.
  always_comb begin
    res_data = '0;
    res_ovf  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_ch == CH_W'(i)) begin
        res_data = lane_nxt[i];
        res_ovf  = lane_ovf[i];
      end
    end
  end

  // Output stage next state: load on a valid accept, drop on drain, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (accept && ch_ok) begin
      out_valid_d = 1'b1;
      out_ch_d    = in_ch;
      out_data_d  = res_data;
      out_ovf_d   = res_ovf;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; reset drops any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_acc_bank.sv
// Self-checking bench for acc_bank (WIDTH=8, CHANNELS=4). A reference model
// predicts each accepted result into a queue; the monitor compares the queue
// head against the output register every cycle it is valid and pops on drain.
// Directed checks against fixed constants follow the test plan.
module tb_acc_bank;
  localparam int W = 8;
  localparam int C = 4;
  localparam logic [1:0] LD = 2'b00, AD = 2'b01, SB = 2'b10, CL = 2'b11;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [1:0]   in_op, in_ch, out_ch;
  logic [W-1:0] in_data, out_data;
  logic [C-1:0] ovf_sticky;

  acc_bank #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .out_ovf(out_ovf), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] d;
    logic         ovf;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] m_acc [C];
  logic [C-1:0] m_sticky;
  int           n_chk = 0, n_err = 0;

`ifdef ACC_BANK_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor + model: check the current output register against the queue
  // head, then predict what the coming edge does.
  always @(negedge clk) begin
    logic         acc_m, ov;
    logic [W:0]   x;
    logic [W-1:0] nv;
    exp_t         e;
    if (rst !== 1'b1) begin
      chk("sb_valid", out_valid, sb_q.size() != 0);
      chk("sb_ready", in_ready, (sb_q.size() == 0) || out_ready);
      chk("sb_sticky", ovf_sticky, m_sticky);
      if (sb_q.size() != 0) begin
        chk("sb_ch",   out_ch,   sb_q[0].ch);
        chk("sb_data", out_data, sb_q[0].d);
        chk("sb_ovf",  out_ovf,  sb_q[0].ovf);
      end
    end
    if (rst === 1'b1) begin
      sb_q.delete();
      for (int i = 0; i < C; i++) m_acc[i] = '0;
      m_sticky = '0;
    end else begin
      acc_m = in_valid && ((sb_q.size() == 0) || out_ready);
      if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
      if (acc_m) begin
        ov = 1'b0;
        nv = '0;
        case (in_op)
          LD: nv = in_data;
          AD: begin
            x  = {1'b0, m_acc[in_ch]} + {1'b0, in_data};
            ov = x[W];
            nv = (ov && SAT) ? {W{1'b1}} : x[W-1:0];
          end
          SB: begin
            ov = in_data > m_acc[in_ch];
            x  = {1'b0, m_acc[in_ch]} - {1'b0, in_data};
            nv = (ov && SAT) ? '0 : x[W-1:0];
          end
          default: nv = '0;
        endcase
        m_acc[in_ch] = nv;
        if (in_op == LD || in_op == CL) m_sticky[in_ch] = 1'b0;
        else if (ov)                    m_sticky[in_ch] = 1'b1;
        e.ch = in_ch; e.d = nv; e.ovf = ov;
        sb_q.push_back(e);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request, accepted at the next edge (out_ready held high by caller).
  task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [W-1:0] d);
    in_valid = 1'b1; in_op = op; in_ch = ch; in_data = d;
    tick;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = LD; in_ch = '0; in_data = '0; out_ready = 1'b1;
    tick; tick;
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_ready", in_ready, 1);

    send(LD, 2'd0, 8'h10);
    chk("ld0_valid", out_valid, 1);
    chk("ld0_data", out_data, 8'h10);
    chk("ld0_ch", out_ch, 0);
    chk("ld0_ovf", out_ovf, 0);
    send(AD, 2'd0, 8'h05);
    chk("add0_data", out_data, 8'h15);

    send(LD, 2'd1, 8'hF0);
    send(AD, 2'd1, 8'h20);
    chk("add1_data", out_data, SAT ? 8'hFF : 8'h10);
    chk("add1_ovf", out_ovf, 1);
    chk("add1_sticky", ovf_sticky[1], 1);
    send(CL, 2'd1, 8'hAA);
    chk("clr1_data", out_data, 8'h00);
    chk("clr1_sticky", ovf_sticky[1], 0);

    send(LD, 2'd2, 8'h03);
    send(SB, 2'd2, 8'h05);
    chk("sub2_data", out_data, SAT ? 8'h00 : 8'hFE);
    chk("sub2_ovf", out_ovf, 1);
    chk("sub2_ch", out_ch, 2);
    send(AD, 2'd0, 8'h00);
    chk("ch0_kept", out_data, 8'h15);

    // Backpressure with a request waiting.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = AD; in_ch = 2'd3; in_data = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_ready", in_ready, 0);
      chk("bp_data", out_data, 8'h15);
      chk("bp_valid", out_valid, 1);
    end
    // Drain and stream ch3 from 0.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk("stream_data", out_data, i);
      chk("stream_ch", out_ch, 3);
    end
    in_valid = 1'b0;
    tick;
    chk("idle_valid", out_valid, 0);

    // Reset while a result is pending and a request is offered.
    send(LD, 2'd2, 8'h77);
    in_valid = 1'b1; in_op = AD; in_ch = 2'd0; in_data = 8'h07;
    rst = 1'b1;
    tick;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst2_valid", out_valid, 0);
    chk("rst2_sticky", ovf_sticky, 0);
    send(AD, 2'd0, 8'h01);
    chk("post_rst_ch0", out_data, 8'h01);
    send(AD, 2'd2, 8'h00);
    chk("post_rst_ch2", out_data, 8'h00);

    // Let the scoreboard drain within a bounded window.
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick;
    tick;
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
